mii_block_packer: RTL and testbench
===================================

Name: mii_block_packer

Overview:
- Sits directly downstream of the byte-wide MII/XGMII-style frame generator.
- Consumes one 8-bit character plus a control flag per accepted cycle and packs eight consecutive characters into a 64-bit data block with an 8-bit control block, for the 64b/66b encoder.
- Realigns Start to lane 0, checks frame structure (Start/Data/Terminate ordering, legal control codes) and flags violations.

Parameters:
- DATA_WIDTH, 64, output data block width; must be 8 × CTRL_WIDTH.
- CTRL_WIDTH, DATA_WIDTH/8, number of lanes and control-block width.
- IDLE_CODE, 8'h07, idle control character; also used as the pad character.
- START_CODE, 8'hFB, start control character.
- TERMINATE_CODE, 8'hFD, terminate control character.
- ERROR_CODE, 8'hFE, error control character (legal code, passed through).

Ports:
- clk  input  1  single clock, rising edge.
- i_rst_n  input  1  asynchronous, active-low reset.
- i_valid  input  1  character on i_tx_data/i_tx_ctrl is accepted this cycle.
- i_tx_data  input  8  MII character.
- i_tx_ctrl  input  1  1 = control character, 0 = data character.
- o_data_block  output  DATA_WIDTH  packed block; lane k is bits [8k+7:8k], lane 0 is first received.
- o_ctrl_block  output  CTRL_WIDTH  bit k = control flag of lane k.
- o_block_valid  output  1  one-cycle strobe; block outputs are valid this cycle.
- o_align  output  1  one-cycle strobe; a padded partial block was flushed because Start arrived off lane 0.
- o_proto_err  output  1  one-cycle strobe; sequence or code violation on the accepted character.
- o_frame_count  output  32  completed frames (Start..Terminate), statistics build only.
- o_err_count  output  32  protocol errors, statistics build only.

Behaviour:
- Reset (async, i_rst_n low) clears all state and outputs:
  - o_data_block = 0, o_ctrl_block = 0, o_block_valid = o_align = o_proto_err = 0, counters = 0.
  - lane_cnt = 0, state = OUT_FRAME.
  - A partial block held at reset assertion is discarded and never emitted.
- Lane fill:
  - Each accepted character writes lane lane_cnt of the assembly register; lane_cnt (3 bits) increments and wraps 7 -> 0.
  - i_valid low: nothing changes and all strobes are 0.
- Latency:
  - When the 8th character is accepted at cycle N, o_block_valid = 1 at N+1 for exactly one cycle.
  - o_data_block/o_ctrl_block are registered and hold their value until the next strobe.
- Start alignment: Start (ctrl=1, data=START_CODE) accepted with lane_cnt ≠ 0:
  - Lanes lane_cnt..7 are padded with IDLE_CODE, ctrl=1.
  - The padded block is emitted at N+1 with o_block_valid = 1 and o_align = 1.
  - Start is written to lane 0 and lane_cnt becomes 1.
  - With lane_cnt = 0, Start goes to lane 0 with no flush.
  - With lane_cnt = 7, 7 held lanes are flushed plus 1 pad lane.
- FSM states: OUT_FRAME, IN_FRAME.
  - OUT_FRAME, Start -> IN_FRAME.
  - OUT_FRAME, IDLE or ERROR code -> stay.
  - OUT_FRAME, data or Terminate -> o_proto_err, stay.
  - IN_FRAME, data or ERROR code -> stay.
  - IN_FRAME, Terminate -> OUT_FRAME, frame counted.
  - IN_FRAME, IDLE -> o_proto_err, OUT_FRAME.
  - IN_FRAME, Start -> o_proto_err, stay IN_FRAME (treated as a new frame, alignment rule still applies).
- Any ctrl=1 code outside {IDLE, START, TERMINATE, ERROR}: o_proto_err = 1, and the lane is replaced by ERROR_CODE with ctrl=1.
- All strobes assert at N+1 relative to the accepted character and are never asserted while i_valid was low at N.

Optional Feature:
- Macro: MII_PACKER_STATS_EN.
- Defined:
  - o_frame_count increments on each Terminate in IN_FRAME.
  - o_err_count increments on each o_proto_err.
  - Both counters are 32-bit, saturate at all-ones, and are cleared by reset.
- Undefined: counter logic is not built; both ports are driven constant 0.

Decomposition:
- Shared package mii_pkg:
  - Control-code constants (IDLE/START/TERMINATE/ERROR).
  - The FSM state enum (OUT_FRAME, IN_FRAME).
  - Lane-count typedef.
  - Function is_legal_ctrl(code).
- One natural sub-module, mii_frame_checker: the FSM plus error/statistics logic. It takes the accepted character and returns the error and frame-done pulses. The lane assembly and flush logic stays in mii_block_packer.

Test Plan:
- 8 IDLE characters then Start, 7×8'hAA data → block 1: data 64'h0707070707070707, ctrl 8'hFF. Block 2: lane0 FB, lanes1-7 AA, ctrl 8'h01. No errors.
- 3 IDLE then Start → padded block 64'h0707070707070707, ctrl 8'hFF, o_align = 1 the cycle after Start. Next block has FB in lane 0.
- Frame ending with Terminate in lane 4, then IDLE ×3 → data 64'h070707FDAAAAAAAA, ctrl 8'hF0. Frame count +1 (stats build).
- Data 8'hAA with ctrl=0 while OUT_FRAME → o_proto_err = 1 one cycle after. In the stats build, err count = 1.
- Illegal control code 8'h9C with ctrl=1 → that lane carries FE, ctrl bit set, o_proto_err pulse.
- i_rst_n low after 5 characters accepted, then 8 IDLE → no block from the partial data; the first block after reset is all IDLE; every output reads 0 during reset.

Source files
------------

// File: rtl/mii_pkg.sv
// Shared definitions for the MII block packer.
//   - Control-code constants (idle, start, terminate, error).
//   - Frame-state enum used by the frame checker.
//   - Lane-count type. It holds eight lanes, so it assumes CTRL_WIDTH = 8.
//   - is_legal_ctrl(): true for the four control codes that may appear on
//     the MII with ctrl = 1.
package mii_pkg;

    localparam logic [7:0] MII_IDLE      = 8'h07;
    localparam logic [7:0] MII_START     = 8'hFB;
    localparam logic [7:0] MII_TERMINATE = 8'hFD;
    localparam logic [7:0] MII_ERROR     = 8'hFE;

    localparam int LANES = 8;

    typedef logic [2:0] lane_t;

    typedef enum logic {
        OUT_FRAME = 1'b0,
        IN_FRAME  = 1'b1
    } frame_state_t;

    function automatic logic is_legal_ctrl(input logic [7:0] code);
        return (code == MII_IDLE) || (code == MII_START) ||
               (code == MII_TERMINATE) || (code == MII_ERROR);
    endfunction

endpackage

// File: rtl/mii_frame_checker.sv
// Frame-structure checker for the MII block packer.
// It tracks Start/Terminate framing, pulses proto_err one cycle after an
// accepted character breaks the sequence or uses an unknown control code,
// and, when MII_PACKER_STATS_EN is defined, keeps saturating frame and
// error counters. When that macro is undefined, both counters are tied to 0.
//
// Ports:
//   clk, rst_n     clock and async active-low reset
//   valid          a character is accepted this cycle
//   data, ctrl     the accepted character and its control flag
//   proto_err      one-cycle strobe, registered
//   frame_count    completed frames (stats build only)
//   err_count      protocol errors (stats build only)
//
// state     | meaning
// OUT_FRAME | between frames; only IDLE/ERROR expected, Start opens a frame
// IN_FRAME  | inside a frame; data/ERROR expected, Terminate closes it
module mii_frame_checker
    import mii_pkg::*;
#(
    parameter logic [7:0] IDLE_CODE      = MII_IDLE,
    parameter logic [7:0] START_CODE     = MII_START,
    parameter logic [7:0] TERMINATE_CODE = MII_TERMINATE,
    parameter logic [7:0] ERROR_CODE     = MII_ERROR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid,
    input  logic [7:0]  data,
    input  logic        ctrl,
    output logic        proto_err,
    output logic [31:0] frame_count,
    output logic [31:0] err_count
);

    frame_state_t state, state_next;
    logic is_start, is_term, is_idle, is_legal, err_next;

    assign is_start = ctrl && (data == START_CODE);
    assign is_term  = ctrl && (data == TERMINATE_CODE);
    assign is_idle  = ctrl && (data == IDLE_CODE);
    assign is_legal = is_start || is_term || is_idle || (data == ERROR_CODE);

    always_comb begin
        state_next = state;
        err_next   = 1'b0;
        if (valid) begin
            case (state)
                OUT_FRAME: begin
                    if (is_start)
                        state_next = IN_FRAME;
                    else if (!ctrl || is_term || !is_legal)
                        err_next = 1'b1;
                end
                IN_FRAME: begin
                    if (is_term) begin
                        state_next = OUT_FRAME;
                    end else if (is_idle) begin
                        err_next   = 1'b1;
                        state_next = OUT_FRAME;
                    end else if (is_start || (ctrl && !is_legal)) begin
                        // A repeated Start restarts the frame, so the
                        // state stays IN_FRAME.
                        err_next = 1'b1;
                    end
                end
                default: state_next = OUT_FRAME;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= OUT_FRAME;
            proto_err <= 1'b0;
        end else begin
            state     <= state_next;
            proto_err <= err_next;
        end
    end

`ifdef MII_PACKER_STATS_EN
    logic done_next;
    assign done_next = valid && (state == IN_FRAME) && is_term;

    // The counters update on the same edge as the proto_err strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            if (done_next && (frame_count != '1))
                frame_count <= frame_count + 32'd1;
            if (err_next && (err_count != '1))
                err_count <= err_count + 32'd1;
        end
    end
`else
    assign frame_count = '0;
    assign err_count   = '0;
`endif

endmodule

// File: rtl/mii_block_packer.sv
// Packs byte-wide MII characters into 64-bit data blocks with an 8-bit
// control block for the 64b/66b encoder.
//   - A Start that arrives off lane 0 flushes the partial block, padded with
//     IDLE, and is then moved to lane 0.
//   - Unknown control codes are replaced by ERROR_CODE in the block.
//   - Optional statistics counters are built when MII_PACKER_STATS_EN is
//     defined.
//
// Ports:
//   clk, i_rst_n               clock and async active-low reset
//   i_valid                    i_tx_data/i_tx_ctrl are accepted this cycle
//   i_tx_data, i_tx_ctrl       MII character and control flag
//   o_data_block, o_ctrl_block packed block; lane 0 is the first received
//   o_block_valid              one-cycle strobe, block outputs are new
//   o_align                    one-cycle strobe, padded flush caused by Start
//   o_proto_err                one-cycle strobe, framing or code violation
//   o_frame_count, o_err_count statistics (0 unless MII_PACKER_STATS_EN)
module mii_block_packer
    import mii_pkg::*;
#(
    parameter int         DATA_WIDTH     = 64,
    parameter int         CTRL_WIDTH     = DATA_WIDTH / 8,
    parameter logic [7:0] IDLE_CODE      = MII_IDLE,
    parameter logic [7:0] START_CODE     = MII_START,
    parameter logic [7:0] TERMINATE_CODE = MII_TERMINATE,
    parameter logic [7:0] ERROR_CODE     = MII_ERROR
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_valid,
    input  logic [7:0]            i_tx_data,
    input  logic                  i_tx_ctrl,
    output logic [DATA_WIDTH-1:0] o_data_block,
    output logic [CTRL_WIDTH-1:0] o_ctrl_block,
    output logic                  o_block_valid,
    output logic                  o_align,
    output logic                  o_proto_err,
    output logic [31:0]           o_frame_count,
    output logic [31:0]           o_err_count
);

    logic [DATA_WIDTH-1:0] asm_data, fill_data, pad_data;
    logic [CTRL_WIDTH-1:0] asm_ctrl, fill_ctrl, pad_ctrl;
    lane_t                 lane_cnt;
    logic                  is_start, is_illegal;
    logic [7:0]            lane_char;

    assign is_start   = i_tx_ctrl && (i_tx_data == START_CODE);
    assign is_illegal = i_tx_ctrl &&
                        (i_tx_data != IDLE_CODE) && (i_tx_data != START_CODE) &&
                        (i_tx_data != TERMINATE_CODE) && (i_tx_data != ERROR_CODE);
    assign lane_char  = is_illegal ? ERROR_CODE : i_tx_data;

    // fill_*: the assembly register with the incoming character written into
    //         the current lane.
    // pad_*:  the assembly register with the current lane and every later
    //         lane replaced by IDLE. Used when Start forces an early flush.
    always_comb begin
        fill_data = asm_data;
        fill_ctrl = asm_ctrl;
        fill_data[{lane_cnt, 3'b000} +: 8] = lane_char;
        fill_ctrl[lane_cnt]                = i_tx_ctrl;
        pad_data = asm_data;
        pad_ctrl = asm_ctrl;
        for (int k = 0; k < CTRL_WIDTH; k++) begin
            if (lane_t'(k) >= lane_cnt) begin
                pad_data[k*8 +: 8] = IDLE_CODE;
                pad_ctrl[k]        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            asm_data      <= '0;
            asm_ctrl      <= '0;
            lane_cnt      <= '0;
            o_data_block  <= '0;
            o_ctrl_block  <= '0;
            o_block_valid <= 1'b0;
            o_align       <= 1'b0;
        end else begin
            o_block_valid <= 1'b0;
            o_align       <= 1'b0;
            if (i_valid) begin
                if (is_start && (lane_cnt != '0)) begin
                    o_data_block  <= pad_data;
                    o_ctrl_block  <= pad_ctrl;
                    o_block_valid <= 1'b1;
                    o_align       <= 1'b1;
                    asm_data[7:0] <= START_CODE;
                    asm_ctrl[0]   <= 1'b1;
                    lane_cnt      <= lane_t'(1);
                end else begin
                    asm_data <= fill_data;
                    asm_ctrl <= fill_ctrl;
                    if (lane_cnt == lane_t'(LANES - 1)) begin
                        o_data_block  <= fill_data;
                        o_ctrl_block  <= fill_ctrl;
                        o_block_valid <= 1'b1;
                    end
                    lane_cnt <= lane_cnt + lane_t'(1);
                end
            end
        end
    end

    mii_frame_checker #(
        .IDLE_CODE      (IDLE_CODE),
        .START_CODE     (START_CODE),
        .TERMINATE_CODE (TERMINATE_CODE),
        .ERROR_CODE     (ERROR_CODE)
    ) u_checker (
        .clk         (clk),
        .rst_n       (i_rst_n),
        .valid       (i_valid),
        .data        (i_tx_data),
        .ctrl        (i_tx_ctrl),
        .proto_err   (o_proto_err),
        .frame_count (o_frame_count),
        .err_count   (o_err_count)
    );

endmodule

// File: tb/tb_mii_block_packer.sv
module tb_mii_block_packer;

    logic        clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic [7:0]  i_tx_data;
    logic        i_tx_ctrl;
    logic [63:0] o_data_block;
    logic [7:0]  o_ctrl_block;
    logic        o_block_valid;
    logic        o_align;
    logic        o_proto_err;
    logic [31:0] o_frame_count;
    logic [31:0] o_err_count;

    int checks = 0;
    int errors = 0;

`ifdef MII_PACKER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    always #5 clk = ~clk;

    mii_block_packer dut (
        .clk           (clk),
        .i_rst_n       (i_rst_n),
        .i_valid       (i_valid),
        .i_tx_data     (i_tx_data),
        .i_tx_ctrl     (i_tx_ctrl),
        .o_data_block  (o_data_block),
        .o_ctrl_block  (o_ctrl_block),
        .o_block_valid (o_block_valid),
        .o_align       (o_align),
        .o_proto_err   (o_proto_err),
        .o_frame_count (o_frame_count),
        .o_err_count   (o_err_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present one character starting at a falling edge. When the task
    // returns, the outputs registered for that character are visible.
    task automatic send(input logic [7:0] d, input logic c);
        i_valid   = 1'b1;
        i_tx_data = d;
        i_tx_ctrl = c;
        @(negedge clk);
        i_valid   = 1'b0;
    endtask

    task automatic send_n(input int n, input logic [7:0] d, input logic c);
        for (int i = 0; i < n; i++) send(d, c);
    endtask

    task automatic idle_cycle();
        i_valid = 1'b0;
        @(negedge clk);
    endtask

    // Expected counter value: the count in the statistics build, 0 otherwise.
    function automatic logic [63:0] cnt(input int n);
        return STATS ? 64'(n) : 64'd0;
    endfunction

    initial begin
        i_rst_n   = 1'b0;
        i_valid   = 1'b0;
        i_tx_data = 8'h00;
        i_tx_ctrl = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_data", o_data_block, 64'd0);
        chk("rst_ctrl", 64'(o_ctrl_block), 64'd0);
        chk("rst_strobes", {61'd0, o_block_valid, o_align, o_proto_err}, 64'd0);
        chk("rst_counts", {o_frame_count, o_err_count}, 64'd0);
        i_rst_n = 1'b1;
        @(negedge clk);

        // 8 IDLE, then Start followed by 7 data characters.
        send_n(7, 8'h07, 1'b1);
        chk("idle_no_block_early", 64'(o_block_valid), 64'd0);
        send(8'h07, 1'b1);
        chk("idle_blk_valid", 64'(o_block_valid), 64'd1);
        chk("idle_blk_data", o_data_block, 64'h0707070707070707);
        chk("idle_blk_ctrl", 64'(o_ctrl_block), 64'hFF);
        chk("idle_no_err", 64'(o_proto_err), 64'd0);
        idle_cycle();
        chk("strobe_one_cycle", 64'(o_block_valid), 64'd0);
        chk("block_held", o_data_block, 64'h0707070707070707);
        send(8'hFB, 1'b1);
        chk("start_lane0_no_align", {62'd0, o_align, o_block_valid}, 64'd0);
        send_n(7, 8'hAA, 1'b0);
        chk("frame_blk_valid", 64'(o_block_valid), 64'd1);
        chk("frame_blk_data", o_data_block, 64'hAAAAAAAAAAAAAAFB);
        chk("frame_blk_ctrl", 64'(o_ctrl_block), 64'h01);
        chk("frame_no_err", 64'(o_proto_err), 64'd0);

        // Terminate in lane 4, then 3 IDLE.
        send_n(4, 8'hAA, 1'b0);
        send(8'hFD, 1'b1);
        send_n(3, 8'h07, 1'b1);
        chk("term_blk_data", o_data_block, 64'h070707FDAAAAAAAA);
        chk("term_blk_ctrl", 64'(o_ctrl_block), 64'hF0);
        chk("term_no_err", 64'(o_proto_err), 64'd0);
        chk("frame_count_1", 64'(o_frame_count), cnt(1));

        // 3 IDLE, then Start off lane 0, which forces an aligned flush.
        send_n(3, 8'h07, 1'b1);
        send(8'hFB, 1'b1);
        chk("align_strobe", {62'd0, o_align, o_block_valid}, 64'd3);
        chk("align_data", o_data_block, 64'h0707070707070707);
        chk("align_ctrl", 64'(o_ctrl_block), 64'hFF);
        send_n(7, 8'hAA, 1'b0);
        chk("post_align_data", o_data_block, 64'hAAAAAAAAAAAAAAFB);
        chk("post_align_ctrl", 64'(o_ctrl_block), 64'h01);
        chk("post_align_no_align", 64'(o_align), 64'd0);
        send(8'hFD, 1'b1);
        send_n(7, 8'h07, 1'b1);
        chk("term_lane0_data", o_data_block, 64'h07070707070707FD);
        chk("frame_count_2", 64'(o_frame_count), cnt(2));

        // Data while OUT_FRAME, then an illegal control code in lane 1.
        send(8'hAA, 1'b0);
        chk("data_out_frame_err", 64'(o_proto_err), 64'd1);
        chk("err_count_1", 64'(o_err_count), cnt(1));
        send(8'h9C, 1'b1);
        chk("illegal_code_err", 64'(o_proto_err), 64'd1);
        chk("err_count_2", 64'(o_err_count), cnt(2));
        send(8'h07, 1'b1);
        chk("err_strobe_clears", 64'(o_proto_err), 64'd0);
        send_n(5, 8'h07, 1'b1);
        chk("illegal_blk_data", o_data_block, 64'h070707070707FEAA);
        chk("illegal_blk_ctrl", 64'(o_ctrl_block), 64'hFE);

        // IDLE inside a frame is an error and closes the frame.
        send(8'hFB, 1'b1);
        send(8'h07, 1'b1);
        chk("idle_in_frame_err", 64'(o_proto_err), 64'd1);
        send_n(6, 8'h07, 1'b1);
        chk("idle_in_frame_data", o_data_block, 64'h07070707070707FB);
        chk("err_count_3", 64'(o_err_count), cnt(3));

        // Start with lane_cnt = 7, then a second Start inside the frame.
        send_n(7, 8'h07, 1'b1);
        send(8'hFB, 1'b1);
        chk("align7_strobe", {61'd0, o_align, o_block_valid, o_proto_err}, 64'd6);
        chk("align7_data", o_data_block, 64'h0707070707070707);
        send(8'hFB, 1'b1);
        chk("restart_strobe", {61'd0, o_align, o_block_valid, o_proto_err}, 64'd7);
        chk("restart_data", o_data_block, 64'h07070707070707FB);
        chk("restart_ctrl", 64'(o_ctrl_block), 64'hFF);
        send(8'hFD, 1'b1);
        send_n(6, 8'h07, 1'b1);
        chk("restart_term_data", o_data_block, 64'h070707070707FDFB);
        chk("frame_count_3", 64'(o_frame_count), cnt(3));
        chk("err_count_4", 64'(o_err_count), cnt(4));

        // A reset in the middle of a block discards the partial block.
        send(8'hFB, 1'b1);
        send_n(4, 8'hAA, 1'b0);
        i_rst_n = 1'b0;
        #1;
        chk("midrst_data", o_data_block, 64'd0);
        chk("midrst_ctrl", 64'(o_ctrl_block), 64'd0);
        chk("midrst_strobes", {61'd0, o_block_valid, o_align, o_proto_err}, 64'd0);
        chk("midrst_counts", {o_frame_count, o_err_count}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        i_rst_n = 1'b1;
        @(negedge clk);
        send_n(3, 8'h07, 1'b1);
        chk("no_stale_block", 64'(o_block_valid), 64'd0);
        send_n(4, 8'h07, 1'b1);
        chk("no_block_at_7", 64'(o_block_valid), 64'd0);
        send(8'h07, 1'b1);
        chk("postrst_blk_valid", 64'(o_block_valid), 64'd1);
        chk("postrst_data", o_data_block, 64'h0707070707070707);
        chk("postrst_ctrl", 64'(o_ctrl_block), 64'hFF);
        chk("postrst_no_err", 64'(o_proto_err), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
